// File: rtl/ram_writer_mc.sv
// rtl/ram_writer_mc.sv - multi-channel throttled stream to DDR circular buffer writer
//
// Purpose:
//   CHANNELS sample streams each pass through a power-of-two decimator into a
//   one-entry holding register. A round-robin arbiter selects a full holding
//   register, and a single-beat AXI4 write master stores the sample into that
//   channel's circular buffer. A request/ack handshake snapshots every
//   channel's next write index while no write is in flight.
//
// Ports:
//   aclk, areset              clock, synchronous active-high reset
//   S_AXIS_t*                 packed per-channel sample streams
//   cfg_enable                run / accept new samples
//   cfg_request               level request for a position snapshot
//   cfg_log_length            log2 buffer length in words (clamped)
//   cfg_log_throttle          keep one of every 2^n accepted samples
//   cfg_base_addr             byte address of channel 0 buffer
//   status_ack                snapshot valid
//   status_position           per-channel next write index, LOG_LENGTH_MAX bits each
//   M_AXI_aw*/w*/b*           single-beat AXI4 write master
module ram_writer_mc #(
  parameter int CHANNELS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int LOG_LENGTH_MAX = 16
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [CHANNELS*DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic [CHANNELS-1:0]                S_AXIS_tvalid,
  output logic [CHANNELS-1:0]                S_AXIS_tready,
  input  logic                               cfg_enable,
  input  logic                               cfg_request,
  input  logic [4:0]                         cfg_log_length,
  input  logic [4:0]                         cfg_log_throttle,
  input  logic [ADDR_WIDTH-1:0]              cfg_base_addr,
  output logic                               status_ack,
  output logic [CHANNELS*LOG_LENGTH_MAX-1:0] status_position,
  output logic [ADDR_WIDTH-1:0]              M_AXI_awaddr,
  output logic                               M_AXI_awvalid,
  input  logic                               M_AXI_awready,
  output logic [DATA_WIDTH-1:0]              M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]            M_AXI_wstrb,
  output logic                               M_AXI_wvalid,
  input  logic                               M_AXI_wready,
  input  logic                               M_AXI_bvalid,
  output logic                               M_AXI_bready
);

  localparam int BSH = $clog2(DATA_WIDTH/8);
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW  = LOG_LENGTH_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  state_t                        state_q, state_d;
  logic [CHANNELS-1:0]           hold_full_q;
  logic [DATA_WIDTH-1:0]         hold_data_q [CHANNELS];
  logic [31:0]                   thr_q       [CHANNELS];
  logic [IW-1:0]                 idx_q       [CHANNELS];
  logic [4:0]                    len_q;
  logic [CW-1:0]                 last_q, cur_q;
  logic [ADDR_WIDTH-1:0]         awaddr_q;
  logic [DATA_WIDTH-1:0]         wdata_q;
  logic                          aw_done_q, w_done_q;
  logic                          req_q, armed_q, ack_q;
  logic [CHANNELS*IW-1:0]        pos_q;

  logic [4:0]                    len_eff;
  logic [IW-1:0]                 len_mask;
  logic [31:0]                   thr_mask;
  logic                          len_chg;
  logic [CHANNELS-1:0]           s_fire;
  logic                          found;
  logic [CW-1:0]                 pick, cand;
  logic [IW-1:0]                 idx_pick;
  logic [ADDR_WIDTH-1:0]         chan_off, addr_pick;
  logic                          start, aw_fire, w_fire, done;

  assign len_eff  = (32'(cfg_log_length) > LOG_LENGTH_MAX) ? 5'(LOG_LENGTH_MAX) : cfg_log_length;
  assign len_mask = IW'((64'd1 << len_eff) - 64'd1);
  assign thr_mask = (32'd1 << cfg_log_throttle) - 32'd1;
  // A changed length invalidates every index; the write started in the same
  // IDLE cycle already uses the cleared index.
  assign len_chg  = (len_eff != len_q);

  assign S_AXIS_tready = {CHANNELS{cfg_enable}} & ~hold_full_q;
  assign s_fire        = S_AXIS_tvalid & S_AXIS_tready;

  // Round-robin: scan starting one past the last served channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = CW'((int'(last_q) + k) % CHANNELS);
      if (!found && hold_full_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign idx_pick  = len_chg ? '0 : idx_q[pick];
  assign chan_off  = ADDR_WIDTH'(pick) << len_eff;
  assign addr_pick = cfg_base_addr + ((chan_off + ADDR_WIDTH'(idx_pick)) << BSH);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    aw_fire = 1'b0;
    w_fire  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_enable && found) begin
          start   = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        aw_fire = ~aw_done_q & M_AXI_awready;
        w_fire  = ~w_done_q & M_AXI_wready;
        if ((aw_done_q || M_AXI_awready) && (w_done_q || M_AXI_wready)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (M_AXI_bvalid) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      hold_full_q <= '0;
      len_q       <= '0;
      last_q      <= CW'(CHANNELS - 1);
      cur_q       <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_q       <= 1'b0;
      armed_q     <= 1'b0;
      ack_q       <= 1'b0;
      pos_q       <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        hold_data_q[c] <= '0;
        thr_q[c]       <= '0;
        idx_q[c]       <= '0;
      end
    end else begin
      state_q <= state_d;
      req_q   <= cfg_request;

      for (int c = 0; c < CHANNELS; c++) begin
        if (s_fire[c]) begin
          thr_q[c] <= (thr_q[c] + 32'd1) & thr_mask;
          if ((thr_q[c] & thr_mask) == 32'd0) begin
            hold_full_q[c] <= 1'b1;
            hold_data_q[c] <= S_AXIS_tdata[c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      if (state_q == S_IDLE && len_chg) begin
        len_q <= len_eff;
        for (int c = 0; c < CHANNELS; c++) idx_q[c] <= '0;
      end

      if (start) begin
        cur_q     <= pick;
        awaddr_q  <= addr_pick;
        wdata_q   <= hold_data_q[pick];
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;

      if (done) begin
        hold_full_q[cur_q] <= 1'b0;
        idx_q[cur_q]       <= (idx_q[cur_q] + 1'b1) & len_mask;
        last_q             <= cur_q;
      end

      // Rising request edges are ignored while a snapshot is being acknowledged.
      if (cfg_request && !req_q && !ack_q) armed_q <= 1'b1;
      if (state_q == S_IDLE && armed_q) begin
        armed_q <= 1'b0;
        ack_q   <= 1'b1;
        for (int c = 0; c < CHANNELS; c++) pos_q[c*IW +: IW] <= idx_q[c];
      end else if (!cfg_request) begin
        ack_q <= 1'b0;
      end
    end
  end

  assign M_AXI_awaddr    = awaddr_q;
  assign M_AXI_awvalid   = (state_q == S_ADDR) & ~aw_done_q;
  assign M_AXI_wdata     = wdata_q;
  assign M_AXI_wvalid    = (state_q == S_ADDR) & ~w_done_q;
  assign M_AXI_wstrb     = '1;
  assign M_AXI_bready    = 1'b1;
  assign status_ack      = ack_q;
  assign status_position = pos_q;

endmodule

// File: tb/tb_ram_writer_mc.sv
// tb/tb_ram_writer_mc.sv - directed bench for ram_writer_mc
module tb_ram_writer_mc;
  localparam int CH      = 2;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int LEN_MAX = 16;

  logic                  aclk;
  logic                  areset;
  logic [CH*DW-1:0]      s_tdata;
  logic [CH-1:0]         s_tvalid;
  logic [CH-1:0]         s_tready;
  logic                  cfg_enable;
  logic                  cfg_request;
  logic [4:0]            cfg_log_length;
  logic [4:0]            cfg_log_throttle;
  logic [AW-1:0]         cfg_base_addr;
  logic                  status_ack;
  logic [CH*LEN_MAX-1:0] status_position;
  logic [AW-1:0]         awaddr;
  logic                  awvalid, awready;
  logic [DW-1:0]         wdata;
  logic [DW/8-1:0]       wstrb;
  logic                  wvalid, wready, bvalid, bready;

  int vectors     = 0;
  int miscompares = 0;
  int resp_delay  = 0;
  int hs_cnt0     = 0;
  int hs_cnt1     = 0;
  logic [31:0] feed0[$], feed1[$], aw_q[$], w_q[$];

  ram_writer_mc #(.CHANNELS(CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOG_LENGTH_MAX(LEN_MAX)) dut (
    .aclk(aclk), .areset(areset),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .cfg_enable(cfg_enable), .cfg_request(cfg_request),
    .cfg_log_length(cfg_log_length), .cfg_log_throttle(cfg_log_throttle),
    .cfg_base_addr(cfg_base_addr),
    .status_ack(status_ack), .status_position(status_position),
    .M_AXI_awaddr(awaddr), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid),
    .M_AXI_wready(wready), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Stream drivers: present queue heads, pop on each completed handshake.
  initial begin
    bit hs0, hs1;
    s_tvalid = '0;
    s_tdata  = '0;
    forever begin
      @(negedge aclk);
      hs0 = s_tvalid[0] & s_tready[0];
      hs1 = s_tvalid[1] & s_tready[1];
      @(posedge aclk);
      #2;
      if (hs0) begin void'(feed0.pop_front()); hs_cnt0++; end
      if (hs1) begin void'(feed1.pop_front()); hs_cnt1++; end
      if (feed0.size() > 0) begin s_tvalid[0] = 1'b1; s_tdata[31:0]  = feed0[0]; end
      else s_tvalid[0] = 1'b0;
      if (feed1.size() > 0) begin s_tvalid[1] = 1'b1; s_tdata[63:32] = feed1[0]; end
      else s_tvalid[1] = 1'b0;
    end
  end

  // AXI slave: log handshakes, answer each completed write with a one-cycle bvalid.
  initial begin
    bit aw_now, w_now, rst_now, aw_s, w_s, bp;
    int bc;
    aw_s = 0; w_s = 0; bp = 0; bc = 0;
    bvalid = 1'b0;
    forever begin
      @(negedge aclk);
      aw_now  = awvalid & awready;
      w_now   = wvalid & wready;
      rst_now = areset;
      if (aw_now) aw_q.push_back(awaddr);
      if (w_now)  w_q.push_back(wdata);
      @(posedge aclk);
      #1;
      if (bvalid) bvalid = 1'b0;
      if (rst_now) begin
        aw_s = 0; w_s = 0; bp = 0;
        continue;
      end
      if (aw_now) aw_s = 1;
      if (w_now)  w_s  = 1;
      if (bp) begin
        if (bc == 0) begin bvalid = 1'b1; bp = 0; end
        else bc--;
      end else if (aw_s && w_s) begin
        aw_s = 0; w_s = 0;
        if (resp_delay == 0) bvalid = 1'b1;
        else begin bp = 1; bc = resp_delay - 1; end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic drive_slot();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && aw_q.size() < n; i++) begin
      @(negedge aclk);
      #1;
    end
    chk(tag, 64'(aw_q.size()), 64'(n));
  endtask

  initial begin
    logic [31:0] ea2 [8];
    logic [31:0] ed2 [8];
    int h0;
    ea2 = '{32'h1040, 32'h1004, 32'h1044, 32'h1008, 32'h1048, 32'h100C, 32'h104C, 32'h1010};
    ed2 = '{32'h200, 32'h100, 32'h201, 32'h101, 32'h202, 32'h102, 32'h203, 32'h103};

    areset = 1'b1;
    cfg_enable = 1'b0;
    cfg_request = 1'b0;
    cfg_log_length = 5'd4;
    cfg_log_throttle = 5'd0;
    cfg_base_addr = 32'h1000;
    awready = 1'b1;
    wready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd1);
    chk("rst_wstrb", 64'(wstrb), 64'hF);
    chk("rst_ack", 64'(status_ack), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("rst_pos", 64'(status_position), 64'd0);
    drive_slot();
    areset = 1'b0;
    cfg_enable = 1'b1;
    @(negedge aclk);
    chk("en_tready", 64'(s_tready), 64'h3);

    // Single channel sweep through the whole buffer and wrap
    drive_slot();
    for (int i = 0; i < 17; i++) feed0.push_back(32'(i));
    wait_writes(17, 400, "t1_count");
    for (int i = 0; i < 17 && i < aw_q.size(); i++) begin
      chk($sformatf("t1_addr%0d", i), 64'(aw_q[i]), 64'(32'h1000 + 4 * (i % 16)));
      chk($sformatf("t1_data%0d", i), 64'(w_q[i]), 64'(i));
    end
    repeat (6) drive_slot();

    // Both channels contending
    aw_q.delete(); w_q.delete();
    for (int i = 0; i < 4; i++) begin
      feed0.push_back(32'h100 + 32'(i));
      feed1.push_back(32'h200 + 32'(i));
    end
    wait_writes(8, 300, "t2_count");
    for (int i = 0; i < 8 && i < aw_q.size(); i++) begin
      chk($sformatf("t2_addr%0d", i), 64'(aw_q[i]), 64'(ea2[i]));
      chk($sformatf("t2_data%0d", i), 64'(w_q[i]), 64'(ed2[i]));
    end
    repeat (6) drive_slot();

    // Throttle 1 of 4
    aw_q.delete(); w_q.delete();
    cfg_log_throttle = 5'd2;
    h0 = hs_cnt0;
    for (int i = 0; i < 16; i++) feed0.push_back(32'(i));
    for (int i = 0; i < 300 && feed0.size() > 0; i++) @(negedge aclk);
    repeat (12) drive_slot();
    chk("t3_handshakes", 64'(hs_cnt0 - h0), 64'd16);
    chk("t3_count", 64'(aw_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < aw_q.size(); i++) begin
      chk($sformatf("t3_addr%0d", i), 64'(aw_q[i]), 64'(32'h1014 + 4 * i));
      chk($sformatf("t3_data%0d", i), 64'(w_q[i]), 64'(4 * i));
    end
    cfg_log_throttle = 5'd0;

    // Delayed awready, late bvalid
    aw_q.delete(); w_q.delete();
    awready = 1'b0;
    resp_delay = 2;
    feed1.push_back(32'h300);
    for (int i = 0; i < 20 && !awvalid; i++) @(negedge aclk);
    chk("t4_aw_up", 64'(awvalid), 64'd1);
    chk("t4_w_up", 64'(wvalid), 64'd1);
    feed0.push_back(32'h400);
    @(negedge aclk);
    chk("t4_w_drop", 64'(wvalid), 64'd0);
    chk("t4_aw_hold1", 64'(awvalid), 64'd1);
    @(negedge aclk);
    chk("t4_aw_hold2", 64'(awvalid), 64'd1);
    drive_slot();
    awready = 1'b1;
    @(negedge aclk);
    chk("t4_aw_hold3", 64'(awvalid), 64'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      chk("t4_no_overlap", 64'(awvalid), 64'd0);
      if (bvalid) break;
    end
    chk("t4_bvalid", 64'(bvalid), 64'd1);
    wait_writes(2, 60, "t4_count");
    if (aw_q.size() >= 2) begin
      chk("t4_addr0", 64'(aw_q[0]), 64'h1050);
      chk("t4_data0", 64'(w_q[0]), 64'h300);
      chk("t4_addr1", 64'(aw_q[1]), 64'h1024);
      chk("t4_data1", 64'(w_q[1]), 64'h400);
    end
    repeat (10) drive_slot();
    resp_delay = 0;

    // Reset while a write is in ADDR
    awready = 1'b0;
    feed0.push_back(32'h500);
    for (int i = 0; i < 20 && !awvalid; i++) @(negedge aclk);
    chk("t6_aw_up", 64'(awvalid), 64'd1);
    drive_slot();
    areset = 1'b1;
    drive_slot();
    @(negedge aclk);
    chk("t6_awvalid", 64'(awvalid), 64'd0);
    chk("t6_wvalid", 64'(wvalid), 64'd0);
    chk("t6_awaddr", 64'(awaddr), 64'd0);
    drive_slot();
    areset = 1'b0;
    awready = 1'b1;
    aw_q.delete(); w_q.delete();
    repeat (10) drive_slot();
    chk("t6_no_write", 64'(aw_q.size()), 64'd0);
    chk("t6_tready", 64'(s_tready), 64'h3);
    feed0.push_back(32'h600);
    wait_writes(1, 40, "t6_count");
    if (aw_q.size() >= 1) begin
      chk("t6_addr", 64'(aw_q[0]), 64'h1000);
      chk("t6_data", 64'(w_q[0]), 64'h600);
    end
    repeat (6) drive_slot();

    // Snapshot requested during the last write's response phase
    resp_delay = 3;
    for (int i = 1; i <= 4; i++) feed0.push_back(32'h600 + 32'(i));
    for (int i = 0; i < 3; i++) feed1.push_back(32'h700 + 32'(i));
    wait_writes(8, 300, "t5_count");
    drive_slot();
    cfg_request = 1'b1;
    @(negedge aclk);
    chk("t5_ack_wait", 64'(status_ack), 64'd0);
    for (int i = 0; i < 30 && !status_ack; i++) @(negedge aclk);
    chk("t5_ack", 64'(status_ack), 64'd1);
    chk("t5_pos", 64'(status_position), 64'h0003_0005);
    drive_slot();
    cfg_request = 1'b0;
    @(negedge aclk);
    chk("t5_ack_hold", 64'(status_ack), 64'd1);
    @(negedge aclk);
    chk("t5_ack_clr", 64'(status_ack), 64'd0);
    chk("t5_pos_hold", 64'(status_position), 64'h0003_0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
